// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared defaults and the ceil-log2 helper for the multiplier scheduler.
package mult_share_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mult_result_fifo.sv
// mult_result_fifo: synchronous first-word-fall-through buffer with occupancy count.
module mult_result_fifo
  import mult_share_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);
  localparam int AW = clog2(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic do_pop;
  always_comb begin
    do_pop = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rd_data = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin sharing of one multiplier across requesters,
// with credit-limited issue into an in-order result buffer.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATAWIDTH_IN_A = 32,
  parameter int DATAWIDTH_IN_B = 32,
  parameter int DATAWIDTH_OUT  = 60,
  parameter int OUTADDR        = 4,
  parameter int INVERSE        = 0,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [NUM_REQ-1:0]                  s_req_tvalid,
  output logic [NUM_REQ-1:0]                  s_req_tready,
  input  logic [NUM_REQ*DATAWIDTH_IN_A-1:0]   s_req_a_tdata,
  input  logic [NUM_REQ*DATAWIDTH_IN_B-1:0]   s_req_b_tdata,
  output logic                                m_result_tvalid,
  input  logic                                m_result_tready,
  output logic [DATAWIDTH_OUT-1:0]            m_result_tdata,
  output logic [clog2(NUM_REQ)-1:0]           m_result_tuser
);
  localparam int ID_W = clog2(NUM_REQ);
  localparam int PW = DATAWIDTH_IN_A + DATAWIDTH_IN_B;
  localparam int XW = PW + DATAWIDTH_OUT + OUTADDR;
  localparam int FW = DATAWIDTH_OUT + ID_W;
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, scan_idx;
  logic found, grant;
  logic [DATAWIDTH_IN_A-1:0] a_sel;
  logic [DATAWIDTH_IN_B-1:0] b_sel;
  logic [PW-1:0] prod;
  logic [XW-1:0] ext, shifted;
  logic [DATAWIDTH_OUT-1:0] res;
  logic mul_valid_q, mul_valid_d;
  logic [DATAWIDTH_OUT-1:0] mul_data_q, mul_data_d;
  logic [ID_W-1:0] mul_id_q, mul_id_d;
  logic [FW-1:0] fifo_rd;
  logic [CW-1:0] fifo_cnt;
  logic fifo_empty;
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && s_req_tvalid[scan_idx]) begin
        found = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    // Credit covers buffered plus in-flight results; a same-cycle pop is deliberately ignored.
    grant = found && !areset && (int'(fifo_cnt) + int'(mul_valid_q) < FIFO_DEPTH);
    s_req_tready = '0;
    s_req_tready[gnt_idx] = grant;
    a_sel = s_req_a_tdata[int'(gnt_idx)*DATAWIDTH_IN_A +: DATAWIDTH_IN_A];
    b_sel = s_req_b_tdata[int'(gnt_idx)*DATAWIDTH_IN_B +: DATAWIDTH_IN_B];
    prod = PW'(a_sel) * PW'(b_sel);
    ext = XW'(prod);
    shifted = (INVERSE != 0) ? (ext << OUTADDR) : (ext >> OUTADDR);
    res = (shifted[DATAWIDTH_OUT-1:0] == '0) ? DATAWIDTH_OUT'(1) : shifted[DATAWIDTH_OUT-1:0];
    rr_ptr_d = grant ? ((int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
    mul_valid_d = grant;
    mul_data_d = grant ? res : mul_data_q;
    mul_id_d = grant ? gnt_idx : mul_id_q;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr_q <= '0;
      mul_valid_q <= 1'b0;
      mul_data_q <= '0;
      mul_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      mul_valid_q <= mul_valid_d;
      mul_data_q <= mul_data_d;
      mul_id_q <= mul_id_d;
    end
  end
  mult_result_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push    (mul_valid_q),
    .wr_data ({mul_id_q, mul_data_q}),
    .pop     (m_result_tvalid && m_result_tready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );
  assign m_result_tvalid = !fifo_empty && !areset;
  assign m_result_tdata = fifo_rd[DATAWIDTH_OUT-1:0];
  assign m_result_tuser = fifo_rd[FW-1 -: ID_W];
endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: directed and random stimulus checked against a queue-based reference model.
module tb_mult_share_sched;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 60;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [N-1:0] vld, trd0, trd1;
  logic [N*AW-1:0] ad, bd;
  logic rdy, v0, v1;
  logic [DW-1:0] d0, d1;
  logic [1:0] u0, u1;
  typedef struct {
    int id;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    int avail;
  } ent_t;
  ent_t q[$];
  int rr = 0;
  int cyc = 0;
  int vectors = 0;
  int errs = 0;

  always #5 aclk = ~aclk;

  mult_share_sched u_fwd (
    .aclk(aclk), .areset(areset), .s_req_tvalid(vld), .s_req_tready(trd0),
    .s_req_a_tdata(ad), .s_req_b_tdata(bd), .m_result_tvalid(v0),
    .m_result_tready(rdy), .m_result_tdata(d0), .m_result_tuser(u0)
  );
  mult_share_sched #(.INVERSE(1)) u_inv (
    .aclk(aclk), .areset(areset), .s_req_tvalid(vld), .s_req_tready(trd1),
    .s_req_a_tdata(ad), .s_req_b_tdata(bd), .m_result_tvalid(v1),
    .m_result_tready(rdy), .m_result_tdata(d1), .m_result_tuser(u1)
  );

  function automatic logic [DW-1:0] ref_res(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit inv);
    logic [127:0] p;
    p = 128'(a) * 128'(b);
    p = inv ? (p << 4) : (p >> 4);
    return (p[DW-1:0] == '0) ? DW'(1) : p[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ad[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
      bd[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    end
  endtask

  task automatic tick();
    int g;
    logic [N-1:0] et;
    bit ev;
    @(negedge aclk);
    g = -1;
    if (!areset && q.size() < 4)
      for (int k = 0; k < N; k++) if (g < 0 && vld[(rr + k) % N]) g = (rr + k) % N;
    et = '0;
    if (g >= 0) et[g] = 1'b1;
    ev = !areset && q.size() > 0 && q[0].avail <= cyc;
    chk("tready", 64'(trd0), 64'(et));
    chk("tready_inv", 64'(trd1), 64'(et));
    chk("tvalid", 64'(v0), 64'(ev));
    chk("tvalid_inv", 64'(v1), 64'(ev));
    if (ev) begin
      chk("tdata", 64'(d0), 64'(q[0].r0));
      chk("tdata_inv", 64'(d1), 64'(q[0].r1));
      chk("tuser", 64'(u0), 64'(q[0].id));
      chk("tuser_inv", 64'(u1), 64'(q[0].id));
    end
    if (areset) begin
      q.delete();
      rr = 0;
    end else begin
      if (ev && rdy) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, ref_res(ad[g*AW +: AW], bd[g*AW +: AW], 1'b0),
                      ref_res(ad[g*AW +: AW], bd[g*AW +: AW], 1'b1), cyc + 2});
        rr = (g + 1) % N;
      end
    end
    @(posedge aclk);
    cyc++;
    #1;
  endtask

  initial begin
    rdy = 1'b1;
    vld = '0;
    ad = '0;
    bd = '0;
    repeat (3) tick();
    areset = 1'b0;
    vld = 4'b0001;
    ad[0 +: AW] = 32'h100;
    bd[0 +: AW] = 32'h30;
    tick();
    vld = '0;
    tick();
    chk("r028_valid", 64'(v0), 64'd1);
    chk("r028_data", 64'(d0), 64'h300);
    chk("r028_user", 64'(u0), 64'd0);
    repeat (2) tick();
    vld = 4'b0100;
    ad[2*AW +: AW] = 32'h0;
    bd[2*AW +: AW] = 32'h55;
    tick();
    vld = '0;
    tick();
    chk("r029_data", 64'(d0), 64'd1);
    chk("r029_user", 64'(u0), 64'd2);
    repeat (2) tick();
    vld = 4'b0010;
    ad[AW +: AW] = 32'h3;
    bd[AW +: AW] = 32'h5;
    tick();
    vld = '0;
    tick();
    chk("r032_inv", 64'(d1), 64'hF0);
    chk("r032_fwd", 64'(d0), 64'd1);
    repeat (2) tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    vld = '1;
    repeat (12) begin
      rand_ops();
      tick();
    end
    vld = '0;
    repeat (4) tick();
    vld = '1;
    rdy = 1'b0;
    repeat (10) begin
      rand_ops();
      tick();
    end
    rdy = 1'b1;
    repeat (10) tick();
    vld = '0;
    repeat (4) tick();
    rdy = 1'b0;
    vld = '1;
    repeat (3) begin
      rand_ops();
      tick();
    end
    vld = '0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    rdy = 1'b1;
    vld = 4'b1010;
    tick();
    vld = '0;
    repeat (6) tick();
    repeat (400) begin
      vld = N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      areset = ($urandom_range(0, 49) == 0);
      rand_ops();
      tick();
      areset = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
